// File: rtl/dcache_pkg.sv
// Shared geometry, FSM encoding and address-field helpers for the L1 data cache.
// Optional statistics counters are enabled by defining DCACHE_STATS_EN.
package dcache_pkg;
    localparam int LINES          = 16;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_W         = WORDS_PER_LINE * 32;
    localparam int INDEX_W        = $clog2(LINES);
    localparam int WOFF_W         = $clog2(WORDS_PER_LINE);
    localparam int TAG_W          = 32 - INDEX_W - WOFF_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[31 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
        return a[WOFF_W+2 +: INDEX_W];
    endfunction

    function automatic logic [WOFF_W-1:0] addr_woff(input logic [31:0] a);
        return a[2 +: WOFF_W];
    endfunction

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [INDEX_W-1:0] idx);
        return {tag, idx, {(WOFF_W+2){1'b0}}};
    endfunction

    function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                             input logic [WOFF_W-1:0] woff);
        return line[32*int'(woff) +: 32];
    endfunction
endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays of the direct-mapped cache: asynchronous read,
// single write port used either for a CPU word store or a full-line refill.
module dcache_line_store
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [LINE_W-1:0]  rd_line_o,
    input  logic               wr_en_i,
    input  logic               wr_fill_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [WOFF_W-1:0]  wr_woff_i,
    input  logic [31:0]        wr_word_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [LINE_W-1:0]  wr_line_i
);
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    // Only the status bits are cleared on reset; tag/data are don't-care while invalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            if (wr_fill_i) begin
                valid_q[wr_index_i] <= 1'b1;
                dirty_q[wr_index_i] <= 1'b0;
            end else begin
                dirty_q[wr_index_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            if (wr_fill_i) begin
                tag_q[wr_index_i]  <= wr_tag_i;
                data_q[wr_index_i] <= wr_line_i;
            end else begin
                data_q[wr_index_i][32*int'(wr_woff_i) +: 32] <= wr_word_i;
            end
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache controller.
// Define DCACHE_STATS_EN to add hit_cnt_o/miss_cnt_o access counters.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    output state_t            state_o
);
    // Memory handshake: mem_req_o with mem_we_o/mem_addr_o/mem_data_o stays stable
    // until the cycle mem_ack_i is high; that cycle completes the transfer (and
    // carries mem_data_i on a fetch). An ack while no request is pending is ignored.
    state_t             state;
    logic [TAG_W-1:0]   miss_tag;
    logic [INDEX_W-1:0] miss_index;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [WOFF_W-1:0]  req_woff;
    logic               rd_valid, rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic [LINE_W-1:0]  rd_line;
    logic               hit, idle;
    logic               wr_en, wr_fill;
    logic [INDEX_W-1:0] wr_index;
    logic               addr_lsb_unused;

    assign req_tag   = addr_tag(cpu_addr_i);
    assign req_index = addr_index(cpu_addr_i);
    assign req_woff  = addr_woff(cpu_addr_i);
    assign addr_lsb_unused = ^cpu_addr_i[1:0];

    assign hit         = rd_valid & (rd_tag == req_tag);
    assign idle        = (state == ST_IDLE);
    assign cpu_stall_o = ~idle | (cpu_req_i & ~hit);
    assign cpu_data_o  = (idle & cpu_req_i & hit & ~cpu_we_i) ? word_sel(rd_line, req_woff) : '0;
    assign state_o     = state;

    // Stores merge only as a plain hit in IDLE, so a refill always writes the raw memory line.
    always_comb begin
        wr_en    = 1'b0;
        wr_fill  = 1'b0;
        wr_index = req_index;
        if (idle & cpu_req_i & hit & cpu_we_i) begin
            wr_en = 1'b1;
        end else if ((state == ST_ALLOCATE) & mem_ack_i) begin
            wr_en    = 1'b1;
            wr_fill  = 1'b1;
            wr_index = miss_index;
        end
    end

    dcache_line_store u_store (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_index_i (req_index),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .wr_en_i    (wr_en),
        .wr_fill_i  (wr_fill),
        .wr_index_i (wr_index),
        .wr_woff_i  (req_woff),
        .wr_word_i  (cpu_data_i),
        .wr_tag_i   (miss_tag),
        .wr_line_i  (mem_data_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            miss_tag   <= '0;
            miss_index <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req_i & ~hit) begin
                        miss_tag   <= req_tag;
                        miss_index <= req_index;
                        mem_req_o  <= 1'b1;
                        if (rd_valid & rd_dirty) begin
                            state      <= ST_WRITEBACK;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= line_addr(rd_tag, req_index);
                            mem_data_o <= rd_line;
                        end else begin
                            state      <= ST_ALLOCATE;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= line_addr(req_tag, req_index);
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        state      <= ST_ALLOCATE;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= line_addr(miss_tag, miss_index);
                        mem_data_o <= '0;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ack_i) begin
                        state      <= ST_IDLE;
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= '0;
                        mem_data_o <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // A missed access counts one miss on detection and one hit once the refill lands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (idle & cpu_req_i) begin
            if (hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end else begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif
endmodule
